// File: rtl/lock_pkg.sv
// Shared types and default sizing for the cycle-lock code-entry controller.
package lock_pkg;

    typedef enum logic [1:0] {
        ENTRY,
        CHECK,
        OPEN,
        LOCKOUT
    } lock_state_t;

    localparam int DIGITS_DEFAULT         = 4;
    localparam int DIGIT_W_DEFAULT        = 4;
    localparam int MAX_FAILS_DEFAULT      = 3;
    localparam int UNLOCK_CYCLES_DEFAULT  = 500;
    localparam int LOCKOUT_CYCLES_DEFAULT = 1000;

    // Wide enough to hold the longer of the two timed intervals.
    localparam int TIMER_W = $clog2(((UNLOCK_CYCLES_DEFAULT > LOCKOUT_CYCLES_DEFAULT) ?
                                     UNLOCK_CYCLES_DEFAULT : LOCKOUT_CYCLES_DEFAULT) + 1);

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the OPEN and LOCKOUT intervals.
module lock_timer
    import lock_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;
    logic         running;

    // Counts down to zero after a load, then signals expiry for exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            running <= 1'b0;
        end else if (clear) begin
            count   <= '0;
            running <= 1'b0;
        end else if (load) begin
            count   <= load_val;
            running <= 1'b1;
        end else if (running) begin
            if (count == '0) begin
                running <= 1'b0;
            end else begin
                count <= count - W'(1);
            end
        end
    end

    assign expired = running && (count == '0);

endmodule

// File: rtl/lock_controller.sv
// Code-entry state machine: compares keypad digits with the stored code,
// opens the lock on a match and enforces a timed lockout after repeated failures.
module lock_controller
    import lock_pkg::*;
#(
    parameter int DIGITS         = DIGITS_DEFAULT,
    parameter int DIGIT_W        = DIGIT_W_DEFAULT,
    parameter int MAX_FAILS      = MAX_FAILS_DEFAULT,
    parameter int UNLOCK_CYCLES  = UNLOCK_CYCLES_DEFAULT,
    parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DIGITS*DIGIT_W-1:0]      code_i,
    input  logic                           digit_valid_i,
    input  logic [DIGIT_W-1:0]             digit_i,
    output logic                           digit_ready_o,
    input  logic                           clear_i,
    input  logic                           lock_i,
    output logic                           unlocked_o,
    output logic                           lockout_o,
    output logic                           alarm_o,
    output logic [$clog2(DIGITS+1)-1:0]    digit_cnt_o,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt_o
);

    localparam int CW  = DIGITS * DIGIT_W;
    localparam int DCW = $clog2(DIGITS + 1);
    localparam int FCW = $clog2(MAX_FAILS + 1);
    localparam int TW  = $clog2(((UNLOCK_CYCLES > LOCKOUT_CYCLES) ?
                                 UNLOCK_CYCLES : LOCKOUT_CYCLES) + 1);

    lock_state_t        state, next_state;
    logic [CW-1:0]      code_q;
    logic [CW-1:0]      code_sel;
    logic [DIGIT_W-1:0] exp_digit;
    logic               mismatch;
    logic               accept;
    logic               timer_load;
    logic               timer_clear;
    logic [TW-1:0]      timer_val;
    logic               timer_expired;

    lock_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .clear    (timer_clear),
        .load_val (timer_val),
        .expired  (timer_expired)
    );

    // Digit 0 is checked against the live code because it is latched on that same edge.
    always_comb begin
        code_sel  = (digit_cnt_o == '0) ? code_i : code_q;
        exp_digit = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (digit_cnt_o == DCW'(k)) begin
                exp_digit = code_sel[(DIGITS-1-k)*DIGIT_W +: DIGIT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ENTRY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        timer_load  = 1'b0;
        timer_clear = 1'b0;
        case (state)
            ENTRY: begin
                accept = digit_valid_i && !clear_i;
                if (accept && (digit_cnt_o == DCW'(DIGITS - 1))) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                timer_load = 1'b1;
                if (!mismatch) begin
                    next_state = OPEN;
                end else if (fail_cnt_o >= FCW'(MAX_FAILS - 1)) begin
                    next_state = LOCKOUT;
                end else begin
                    next_state = ENTRY;
                    timer_load = 1'b0;
                end
            end
            OPEN: begin
                if (lock_i) begin
                    next_state  = ENTRY;
                    timer_clear = 1'b1;
                end else if (timer_expired) begin
                    next_state = ENTRY;
                end
            end
            LOCKOUT: begin
                if (timer_expired) begin
                    next_state = ENTRY;
                end
            end
            default: next_state = ENTRY;
        endcase
        timer_val = (next_state == OPEN) ? TW'(UNLOCK_CYCLES - 1) : TW'(LOCKOUT_CYCLES - 1);
    end

    // Attempt bookkeeping: digit count, sticky mismatch, latched code and failure count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_cnt_o <= '0;
            mismatch    <= 1'b0;
            code_q      <= '0;
            fail_cnt_o  <= '0;
        end else begin
            case (state)
                ENTRY: begin
                    if (clear_i) begin
                        digit_cnt_o <= '0;
                        mismatch    <= 1'b0;
                    end else if (accept) begin
                        digit_cnt_o <= digit_cnt_o + DCW'(1);
                        mismatch    <= mismatch | (digit_i != exp_digit);
                        if (digit_cnt_o == '0) begin
                            code_q <= code_i;
                        end
                    end
                end
                CHECK: begin
                    digit_cnt_o <= '0;
                    mismatch    <= 1'b0;
                    if (mismatch) begin
                        fail_cnt_o <= fail_cnt_o + FCW'(1);
                    end else begin
                        fail_cnt_o <= '0;
                    end
                end
                LOCKOUT: begin
                    if (timer_expired) begin
                        fail_cnt_o <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_ready_o <= 1'b1;
            unlocked_o    <= 1'b0;
            lockout_o     <= 1'b0;
            alarm_o       <= 1'b0;
        end else begin
            digit_ready_o <= (next_state == ENTRY);
            unlocked_o    <= (next_state == OPEN);
            lockout_o     <= (next_state == LOCKOUT);
            alarm_o       <= (state == CHECK) && (next_state == LOCKOUT);
        end
    end

endmodule

// File: tb/tb_lock_controller.sv
// Self-checking bench for lock_controller: directed scenarios plus randomized
// traffic, all checked every cycle against a behavioural attempt model.
module tb_lock_controller;

    localparam int DIGITS         = 4;
    localparam int DIGIT_W        = 4;
    localparam int MAX_FAILS      = 3;
    localparam int UNLOCK_CYCLES  = 500;
    localparam int LOCKOUT_CYCLES = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] code_i;
    logic        digit_valid_i;
    logic [3:0]  digit_i;
    logic        digit_ready_o;
    logic        clear_i;
    logic        lock_i;
    logic        unlocked_o;
    logic        lockout_o;
    logic        alarm_o;
    logic [2:0]  digit_cnt_o;
    logic [1:0]  fail_cnt_o;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: an attempt is a list of digits judged as a whole number.
    int          entered[$];
    logic [15:0] latched;
    int          fails;
    int          open_left;
    int          lock_left;
    bit          check_pending;
    bit          alarm_exp;

    lock_controller #(
        .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .MAX_FAILS(MAX_FAILS),
        .UNLOCK_CYCLES(UNLOCK_CYCLES), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .code_i        (code_i),
        .digit_valid_i (digit_valid_i),
        .digit_i       (digit_i),
        .digit_ready_o (digit_ready_o),
        .clear_i       (clear_i),
        .lock_i        (lock_i),
        .unlocked_o    (unlocked_o),
        .lockout_o     (lockout_o),
        .alarm_o       (alarm_o),
        .digit_cnt_o   (digit_cnt_o),
        .fail_cnt_o    (fail_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %0h, expected %0h at time %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        entered.delete();
        latched       = '0;
        fails         = 0;
        open_left     = 0;
        lock_left     = 0;
        check_pending = 1'b0;
        alarm_exp     = 1'b0;
    endtask

    function automatic int enteredValue();
        int v = 0;
        foreach (entered[k]) v = v * (1 << DIGIT_W) + entered[k];
        return v;
    endfunction

    // One rising edge of the reference model, using the inputs held across that edge.
    task automatic modelStep();
        alarm_exp = 1'b0;
        if (!rst_n) begin
            modelReset();
        end else if (check_pending) begin
            check_pending = 1'b0;
            if (enteredValue() == int'(latched)) begin
                open_left = UNLOCK_CYCLES;
                fails     = 0;
            end else if (fails + 1 < MAX_FAILS) begin
                fails++;
            end else begin
                fails     = MAX_FAILS;
                lock_left = LOCKOUT_CYCLES;
                alarm_exp = 1'b1;
            end
            entered.delete();
        end else if (open_left > 0) begin
            open_left = lock_i ? 0 : open_left - 1;
        end else if (lock_left > 0) begin
            lock_left--;
            if (lock_left == 0) fails = 0;
        end else if (clear_i) begin
            entered.delete();
        end else if (digit_valid_i) begin
            if (entered.size() == 0) latched = code_i;
            entered.push_back(int'(digit_i));
            if (entered.size() == DIGITS) check_pending = 1'b1;
        end
    endtask

    task automatic compareAll();
        bit in_entry = !(check_pending || open_left > 0 || lock_left > 0);
        checkOutput("digit_ready", {31'b0, digit_ready_o}, {31'b0, in_entry});
        checkOutput("unlocked",    {31'b0, unlocked_o},    {31'b0, open_left > 0});
        checkOutput("lockout",     {31'b0, lockout_o},     {31'b0, lock_left > 0});
        checkOutput("alarm",       {31'b0, alarm_o},       {31'b0, alarm_exp});
        checkOutput("digit_cnt",   {29'b0, digit_cnt_o},   32'(entered.size()));
        if (lock_left == 0)
            checkOutput("fail_cnt", {30'b0, fail_cnt_o}, 32'(fails));
    endtask

    task automatic applyStimulus(input bit valid, input int digit, input bit clr, input bit lck);
        digit_valid_i = valid;
        digit_i       = 4'(digit);
        clear_i       = clr;
        lock_i        = lck;
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic enterCode(input logic [15:0] value);
        for (int k = DIGITS - 1; k >= 0; k--) applyStimulus(1'b1, int'(value[k*DIGIT_W +: DIGIT_W]), 1'b0, 1'b0);
    endtask

    // Asserts reset mid-cycle and checks that outputs fall back without waiting for a clock.
    task automatic asyncReset();
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        compareAll();
        idle(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        code_i        = 16'h1234;
        digit_valid_i = 1'b0;
        digit_i       = '0;
        clear_i       = 1'b0;
        lock_i        = 1'b0;
        modelReset();
        idle(3);
        rst_n = 1'b1;
        idle(2);

        $display("[TB] correct code opens for the full interval");
        enterCode(16'h1234);
        idle(UNLOCK_CYCLES + 5);

        $display("[TB] single wrong attempt");
        enterCode(16'h1235);
        idle(3);

        $display("[TB] repeated failures trigger lockout, digits dropped meanwhile");
        enterCode(16'h9999);
        enterCode(16'h0000);
        for (int i = 0; i < LOCKOUT_CYCLES / 2; i++) applyStimulus(1'b1, i % 10, 1'b0, 1'b0);
        idle(LOCKOUT_CYCLES / 2 + 5);

        $display("[TB] clear together with a digit drops it");
        applyStimulus(1'b1, 1, 1'b0, 1'b0);
        applyStimulus(1'b1, 2, 1'b0, 1'b0);
        applyStimulus(1'b1, 3, 1'b1, 1'b0);
        enterCode(16'h1234);
        idle(5);

        $display("[TB] lock_i while open, code change mid-entry");
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        idle(UNLOCK_CYCLES);
        applyStimulus(1'b1, 1, 1'b0, 1'b0);
        code_i = 16'h5678;
        applyStimulus(1'b1, 2, 1'b0, 1'b0);
        applyStimulus(1'b1, 3, 1'b0, 1'b0);
        applyStimulus(1'b1, 4, 1'b0, 1'b0);
        idle(9);
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        idle(3);

        $display("[TB] reset during OPEN and during LOCKOUT");
        enterCode(16'h5678);
        idle(20);
        asyncReset();
        enterCode(16'h0001);
        enterCode(16'h0002);
        enterCode(16'h0003);
        idle(100);
        asyncReset();
        enterCode(16'h5678);
        applyStimulus(1'b0, 0, 1'b0, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 12000; i++) begin
            logic [15:0] target;
            int          pos;
            int          d;
            if ($urandom_range(0, 299) == 0) code_i = 16'($urandom);
            target = (entered.size() == 0) ? code_i : latched;
            pos    = entered.size();
            d      = (pos < DIGITS) ? int'(target[(DIGITS-1-pos)*DIGIT_W +: DIGIT_W]) : 0;
            if ($urandom_range(0, 5) == 0) d = int'($urandom_range(0, 15));
            if ($urandom_range(0, 3999) == 0) begin
                asyncReset();
            end else begin
                applyStimulus($urandom_range(0, 3) != 0, d,
                              $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
